leaf_stream_tx: RTL and testbench
=================================

# leaf_stream_tx

Transmit-side endpoint for one BFT stream. It takes a single 32-bit valid/ack user stream and packetizes it into 49-bit BFT packets addressed to a remote leaf input port. It tracks the remote port's receive-buffer space with credits, which are returned as freespace-update packets from the BFT. It is the counterpart of the receive path inside a leaf wrapper and sits between a user kernel output (or the host bridge) and the BFT leaf port.

## Interface
Parameters:
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 4, leaf address width
- NUM_PORT_BITS, 4, port address width
- NUM_ADDR_BITS, 7, remote BRAM address width; initial credit = 2^NUM_ADDR_BITS
- SELF_LEAF, 0, this block's leaf id, used to match returning updates
- SELF_PORT, 0, this block's port id, used to match returning updates

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- din_leaf_bft2tx  in  49  packets from the BFT (credit updates)
- dout_leaf_tx2bft  out  49  registered packets to the BFT
- din_user2tx  in  32  user data word
- vld_user2tx  in  1  user word valid
- ack_tx2user  out  1  word accepted this cycle
- dest_leaf  in  4  destination leaf, sampled while in IDLE
- dest_port  in  4  destination port, sampled while in IDLE
- credits  out  8  current credit count, range 0..128

## Operation
- Packet format:
  - [48] valid
  - [47:44] leaf
  - [43:40] port
  - [39] update flag
  - [38:32] addr
  - [31:0] payload
- Data packet: valid=1, update=0, leaf/port = latched destination, addr = wr_ptr, payload = word.
- wr_ptr is 7 bits, starts at 0, increments per data packet, and wraps from 127 to 0.
- Credit update match: din[48]=1, din[39]=1, din[47:44]=SELF_LEAF and din[43:40]=SELF_PORT. The returned count is din[7:0].
  - Credit rule: credits_next = credits − sent + returned, saturating at 128.
  - The same-cycle send and update case uses this same formula.
- State machine (IDLE, SEND, STALL):
  - IDLE → SEND on vld_user2tx. dest_leaf and dest_port latch on this transition.
  - In SEND, a word is accepted when vld_user2tx=1 and credits>0. The word is emitted as a packet the next cycle.
  - SEND → STALL when credits reaches 0 after a send.
  - STALL → SEND when credits becomes nonzero.
  - SEND → IDLE when a cycle has vld_user2tx=0 and there are no pending words.
- Skid register:
  - A single-word skid register holds the word accepted in the last cycle before credits ran out, so ack never needs a combinational path from credit state.
  - ack_tx2user is registered. It deasserts when credits ≤ 1 and a send occurs, or when the skid register is full.
- Non-matching or non-update input packets are ignored.
- Reset values:
  - dout_leaf_tx2bft = 0
  - ack_tx2user = 0
  - credits = 128
  - wr_ptr = 0
  - state = IDLE
  - skid empty
- Reset mid-operation: any in-flight skid word is dropped. The upstream stream is expected to restart.

## Timing
- Latency: a word accepted at cycle N appears on dout_leaf_tx2bft at N+1.
- dout_leaf_tx2bft is driven every cycle. Its valid bit is 0 on idle cycles. The BFT accepts every valid packet with no backpressure.
- Throughput is one packet per cycle while credits>0.
- Credit update latency: an update arriving at cycle N is visible on credits at N+1. A stalled word can then be sent at N+2.
- ack_tx2user asserts no earlier than one cycle after reset deasserts.

## Configuration
- LEAF_STREAM_TX_STATS_EN:
  - When defined, adds output pkt_count[31:0]. It counts emitted data packets, resets to 0, and wraps at 2^32.
  - When undefined, the port and the counter are absent.

## Structure
- Shared package bft_pkg holds:
  - the packet field offsets (VALID_BIT, LEAF_MSB/LSB, PORT_MSB/LSB, UPDATE_BIT, ADDR_MSB/LSB)
  - a packet struct typedef
  - the tx state enum
- One sub-module, bft_credit_counter, holds the saturating add/subtract credit register and the credits==0 flag.

## Test plan
- Reset, then stream 5 words 0x11..0x15 with dest_leaf=3, dest_port=2 → 5 packets on consecutive cycles with addr 0..4 and [47:40]=0x32; credits ends at 123.
- Stream 130 words with no updates → exactly 128 packets; ack_tx2user low and credits=0; state STALL.
- From STALL, inject an update with leaf/port=SELF and payload 64 → credits=64 after one cycle; the remaining 2 words are sent; addr wraps 127→0.
- A send and a matching update of 10 in the same cycle at credits=50 → credits=59.
- An update with the wrong leaf id, or update bit 0 → credits unchanged.
- Assert reset asynchronously mid-stream → dout valid, ack and wr_ptr go to 0 and credits to 128 immediately; stats pkt_count returns to 0 when LEAF_STREAM_TX_STATS_EN is defined.

Source files
------------

// File: rtl/bft_pkg.sv
// Shared BFT definitions: packet field offsets, packet layout, tx-side states.
package bft_pkg;

    localparam int VALID_BIT  = 48;
    localparam int LEAF_MSB   = 47;
    localparam int LEAF_LSB   = 44;
    localparam int PORT_MSB   = 43;
    localparam int PORT_LSB   = 40;
    localparam int UPDATE_BIT = 39;
    localparam int ADDR_MSB   = 38;
    localparam int ADDR_LSB   = 32;

    // Field widths follow the default 49-bit packet geometry.
    typedef struct packed {
        logic        valid;
        logic [3:0]  leaf;
        logic [3:0]  port;
        logic        update;
        logic [6:0]  addr;
        logic [31:0] payload;
    } bft_pkt_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_STALL = 2'd2
    } tx_state_t;

endpackage

// File: rtl/bft_credit_counter.sv
// Saturating credit register: credits - sent + returned, clamped to MAX_CREDITS.
module bft_credit_counter #(
    parameter int CNT_W       = 8,
    parameter int RET_W       = 8,
    parameter int MAX_CREDITS = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sent,
    input  logic [RET_W-1:0] returned,
    output logic [CNT_W-1:0] credits,
    output logic             zero,
    output logic             next_zero
);

    localparam int SW = CNT_W + 2;

    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] nxt;

    // Next credit value; the caller never sends at zero, so the subtraction cannot underflow.
    always_comb begin
        sum = SW'(credits) + SW'(returned) - SW'(sent);
        nxt = sum[CNT_W-1:0];
        if (sum > SW'(MAX_CREDITS))
            nxt = CNT_W'(MAX_CREDITS);
        next_zero = (nxt == '0);
        zero      = (credits == '0);
    end

    // Credit register, full buffer space on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            credits <= CNT_W'(MAX_CREDITS);
        else
            credits <= nxt;
    end

endmodule

// File: rtl/leaf_stream_tx.sv
// Transmit endpoint for one BFT stream: packetizes a valid/ack user stream
// toward a remote leaf port, gated by credits returned as update packets.
// Optional LEAF_STREAM_TX_STATS_EN adds pkt_count (emitted data packets).
module leaf_stream_tx
    import bft_pkg::*;
#(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 4,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter logic [NUM_LEAF_BITS-1:0] SELF_LEAF = '0,
    parameter logic [NUM_PORT_BITS-1:0] SELF_PORT = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2tx,
    output logic [PACKET_BITS-1:0]   dout_leaf_tx2bft,
    input  logic [PAYLOAD_BITS-1:0]  din_user2tx,
    input  logic                     vld_user2tx,
    output logic                     ack_tx2user,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    output logic [NUM_ADDR_BITS:0]   credits
`ifdef LEAF_STREAM_TX_STATS_EN
    ,
    output logic [31:0]              pkt_count
`endif
);

    localparam int CNT_W       = NUM_ADDR_BITS + 1;
    localparam int MAX_CREDITS = 1 << NUM_ADDR_BITS;

    tx_state_t                 state;
    logic [NUM_LEAF_BITS-1:0]  leaf_q;
    logic [NUM_PORT_BITS-1:0]  port_q;
    logic [NUM_ADDR_BITS-1:0]  wr_ptr;
    logic                      skid_full;
    logic [PAYLOAD_BITS-1:0]   skid_data;

    logic                      upd_hit;
    logic [7:0]                returned;
    logic                      cred_zero, cred_next_zero;
    logic                      accept, send_skid, send_user, send, skid_load;
    logic                      skid_full_n, ack_ok;
    logic [PAYLOAD_BITS-1:0]   send_word;
    bft_pkt_t                  pkt;
    logic                      unused_bits;

    // Address bits of an update packet carry no meaning here.
    assign unused_bits = ^din_leaf_bft2tx[ADDR_MSB:8];

    // Update decode, send selection (skid drains first) and next outgoing packet.
    always_comb begin
        upd_hit = din_leaf_bft2tx[VALID_BIT] && din_leaf_bft2tx[UPDATE_BIT] &&
                  (din_leaf_bft2tx[LEAF_MSB:LEAF_LSB] == SELF_LEAF) &&
                  (din_leaf_bft2tx[PORT_MSB:PORT_LSB] == SELF_PORT);
        returned    = upd_hit ? din_leaf_bft2tx[7:0] : 8'd0;
        accept      = (state == TX_SEND) && vld_user2tx && ack_tx2user;
        send_skid   = skid_full && !cred_zero && (state != TX_IDLE);
        send_user   = accept && !cred_zero && !skid_full;
        send        = send_skid || send_user;
        skid_load   = accept && !send_user;
        skid_full_n = skid_load || (skid_full && !send_skid);
        // Drop ack one cycle early when the last credit is being spent.
        ack_ok      = !skid_full_n && !(send && (credits <= CNT_W'(1)));
        send_word   = send_skid ? skid_data : din_user2tx;
        pkt.valid   = 1'b1;
        pkt.leaf    = leaf_q;
        pkt.port    = port_q;
        pkt.update  = 1'b0;
        pkt.addr    = wr_ptr;
        pkt.payload = send_word;
    end

    bft_credit_counter #(
        .CNT_W       (CNT_W),
        .RET_W       (8),
        .MAX_CREDITS (MAX_CREDITS)
    ) u_credits (
        .clk       (clk),
        .reset     (reset),
        .sent      (send),
        .returned  (returned),
        .credits   (credits),
        .zero      (cred_zero),
        .next_zero (cred_next_zero)
    );

    // Output packet register, write pointer and skid word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_leaf_tx2bft <= '0;
            wr_ptr           <= '0;
            skid_full        <= 1'b0;
            skid_data        <= '0;
        end else begin
            dout_leaf_tx2bft <= send ? pkt : '0;
            if (send)
                wr_ptr <= wr_ptr + NUM_ADDR_BITS'(1);
            skid_full <= skid_full_n;
            if (skid_load)
                skid_data <= din_user2tx;
        end
    end

    // Stream FSM with registered ack; destination latched on leaving IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= TX_IDLE;
            ack_tx2user <= 1'b0;
            leaf_q      <= '0;
            port_q      <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    ack_tx2user <= 1'b0;
                    if (vld_user2tx) begin
                        state       <= TX_SEND;
                        leaf_q      <= dest_leaf;
                        port_q      <= dest_port;
                        ack_tx2user <= !cred_zero;
                    end
                end
                TX_SEND: begin
                    if (cred_next_zero) begin
                        state       <= TX_STALL;
                        ack_tx2user <= 1'b0;
                    end else if (!vld_user2tx && !skid_full_n) begin
                        state       <= TX_IDLE;
                        ack_tx2user <= 1'b0;
                    end else begin
                        ack_tx2user <= ack_ok;
                    end
                end
                TX_STALL: begin
                    ack_tx2user <= 1'b0;
                    if (!cred_zero) begin
                        state       <= TX_SEND;
                        ack_tx2user <= ack_ok;
                    end
                end
                default: begin
                    state       <= TX_IDLE;
                    ack_tx2user <= 1'b0;
                end
            endcase
        end
    end

`ifdef LEAF_STREAM_TX_STATS_EN
    // Emitted data packet count, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pkt_count <= '0;
        else if (send)
            pkt_count <= pkt_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_leaf_stream_tx.sv
// Directed bench for leaf_stream_tx (default SELF_LEAF/SELF_PORT = 0).
module tb_leaf_stream_tx;
    import bft_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [48:0] din_bft = '0;
    logic [48:0] dout;
    logic [31:0] din_user = '0;
    logic        vld = 1'b0;
    logic        ack;
    logic [3:0]  dleaf = '0;
    logic [3:0]  dport = '0;
    logic [7:0]  credits;
`ifdef LEAF_STREAM_TX_STATS_EN
    logic [31:0] pkt_count;
`endif

    leaf_stream_tx dut (
        .clk              (clk),
        .reset            (reset),
        .din_leaf_bft2tx  (din_bft),
        .dout_leaf_tx2bft (dout),
        .din_user2tx      (din_user),
        .vld_user2tx      (vld),
        .ack_tx2user      (ack),
        .dest_leaf        (dleaf),
        .dest_port        (dport),
        .credits          (credits)
`ifdef LEAF_STREAM_TX_STATS_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [48:0] pkts[$];
    int          pcyc[$];
    int          accepted = 0;
    int          target = 0;
    logic [31:0] base = '0;

    // Packet monitor, sampled mid-cycle after the rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (dout[48]) begin
            pkts.push_back(dout);
            pcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] upd(input logic v, input logic [3:0] lf, input logic [3:0] pt,
                                        input logic u, input logic [7:0] cnt);
        upd = {v, lf, pt, u, 7'd0, 24'd0, cnt};
    endfunction

    // Advance n cycles from a falling edge, holding each word until acked.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            bit took;
            took = vld && ack;
            @(negedge clk);
            if (took) accepted++;
            vld      = (accepted < target);
            din_user = base + accepted;
        end
    endtask

    task automatic start(input int n, input logic [31:0] b);
        accepted = 0;
        target   = n;
        base     = b;
        vld      = (n > 0);
        din_user = b;
    endtask

    task automatic do_reset();
        vld     = 1'b0;
        din_bft = '0;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pkts.delete();
        pcyc.delete();
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        // Reset state
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_credits", 64'(credits), 64'd128);
        check("rst_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        check("rst_state", 64'(dut.state), 64'(TX_IDLE));
        do_reset();

        // Five words to leaf 3 port 2
        dleaf = 4'd3; dport = 4'd2;
        start(5, 32'h11);
        run(15);
        check("t1_count", 64'(pkts.size()), 64'd5);
        for (int i = 0; i < 5 && i < pkts.size(); i++) begin
            check("t1_valid", 64'(pkts[i][48]), 64'd1);
            check("t1_dest", 64'(pkts[i][47:40]), 64'h32);
            check("t1_update", 64'(pkts[i][39]), 64'd0);
            check("t1_addr", 64'(pkts[i][38:32]), 64'(i));
            check("t1_payload", 64'(pkts[i][31:0]), 64'(32'h11 + i));
            check("t1_consec", 64'(pcyc[i]), 64'(pcyc[0] + i));
        end
        check("t1_credits", 64'(credits), 64'd123);
        check("t1_state", 64'(dut.state), 64'(TX_IDLE));
`ifdef LEAF_STREAM_TX_STATS_EN
        check("t1_pkt_count", 64'(pkt_count), 64'd5);
`endif

        // 130 words, no updates: credits exhaust after 128
        do_reset();
        dleaf = 4'd5; dport = 4'd1;
        start(130, 32'h100);
        run(200);
        check("t2_count", 64'(pkts.size()), 64'd128);
        check("t2_accepted", 64'(accepted), 64'd128);
        check("t2_ack", 64'(ack), 64'd0);
        check("t2_credits", 64'(credits), 64'd0);
        check("t2_state", 64'(dut.state), 64'(TX_STALL));
        check("t2_dout_idle", 64'(dout[48]), 64'd0);
        if (pkts.size() == 128)
            check("t2_last_addr", 64'(pkts[127][38:32]), 64'd127);

        // Return 64 credits; remaining two words go out, address wraps
        din_bft = upd(1'b1, 4'd0, 4'd0, 1'b1, 8'd64);
        run(1);
        din_bft = '0;
        check("t3_credits_upd", 64'(credits), 64'd64);
        run(10);
        check("t3_count", 64'(pkts.size()), 64'd130);
        if (pkts.size() == 130) begin
            check("t3_wrap_addr0", 64'(pkts[128][38:32]), 64'd0);
            check("t3_wrap_addr1", 64'(pkts[129][38:32]), 64'd1);
            check("t3_payload0", 64'(pkts[128][31:0]), 64'h180);
            check("t3_payload1", 64'(pkts[129][31:0]), 64'h181);
            check("t3_dest", 64'(pkts[129][47:40]), 64'h51);
        end
        check("t3_credits", 64'(credits), 64'd62);
        check("t3_state", 64'(dut.state), 64'(TX_IDLE));

        // Send and matching update in the same cycle at credits=50
        do_reset();
        dleaf = 4'd1; dport = 4'd1;
        start(1000, 32'h0);
        for (int k = 0; k < 200 && credits != 8'd50; k++) run(1);
        check("t4_reach50", 64'(credits), 64'd50);
        check("t4_ack", 64'(ack), 64'd1);
        din_bft = upd(1'b1, 4'd0, 4'd0, 1'b1, 8'd10);
        run(1);
        din_bft = '0;
        check("t4_credits", 64'(credits), 64'd59);
        target = accepted;
        vld    = 1'b0;
        run(3);
        check("t4_hold", 64'(credits), 64'd59);

        // Ignored updates, then saturation
        din_bft = upd(1'b1, 4'd1, 4'd0, 1'b1, 8'd10); run(1); din_bft = '0;
        check("t5_wrong_leaf", 64'(credits), 64'd59);
        din_bft = upd(1'b1, 4'd0, 4'd3, 1'b1, 8'd10); run(1); din_bft = '0;
        check("t5_wrong_port", 64'(credits), 64'd59);
        din_bft = upd(1'b1, 4'd0, 4'd0, 1'b0, 8'd10); run(1); din_bft = '0;
        check("t5_no_update", 64'(credits), 64'd59);
        din_bft = upd(1'b0, 4'd0, 4'd0, 1'b1, 8'd10); run(1); din_bft = '0;
        check("t5_not_valid", 64'(credits), 64'd59);
        din_bft = upd(1'b1, 4'd0, 4'd0, 1'b1, 8'd100); run(1); din_bft = '0;
        check("t5_saturate", 64'(credits), 64'd128);

        // Asynchronous reset mid-stream
        do_reset();
        start(1000, 32'h0);
        run(20);
        check("t6_pre_accepted", 64'(accepted), 64'd19);
        check("t6_pre_credits", 64'(credits), 64'd109);
        check("t6_pre_valid", 64'(dout[48]), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_dout", 64'(dout[48]), 64'd0);
        check("t6_ack", 64'(ack), 64'd0);
        check("t6_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        check("t6_credits", 64'(credits), 64'd128);
        check("t6_state", 64'(dut.state), 64'(TX_IDLE));
`ifdef LEAF_STREAM_TX_STATS_EN
        check("t6_pkt_count", 64'(pkt_count), 64'd0);
`endif
        vld = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
